// File: rtl/dmem_responder.sv
// Wait-state data memory responder: one load/store at a time over req/ready.
// Define DMEM_ADDR_CHECK_EN to report misaligned and out-of-range accesses on err.
module dmem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  we,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ready,
    output logic                  err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                  state, state_next;
    logic [CNT_W-1:0]        wait_cnt, cnt_next;
    logic [DATA_WIDTH-1:0]   addr_q, wdata_q;
    logic                    we_q;

    logic [DATA_WIDTH-1:0]   acc_addr, acc_wdata;
    logic                    acc_we;
    logic                    acc_bad;
    logic [IDX_W-1:0]        word_idx;
    logic                    enter_resp;

    logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

    // With zero wait states the access commits on the accept edge itself,
    // before the operand registers hold anything, so use the live inputs then.
    always_comb begin
        acc_addr  = (state == IDLE) ? addr  : addr_q;
        acc_wdata = (state == IDLE) ? wdata : wdata_q;
        acc_we    = (state == IDLE) ? we    : we_q;
    end

    assign word_idx = acc_addr[IDX_W+1:2];

`ifdef DMEM_ADDR_CHECK_EN
    localparam logic [DATA_WIDTH-1:0] ADDR_LIMIT = DATA_WIDTH'(4 * DEPTH_WORDS);
    assign acc_bad = (acc_addr[1:0] != 2'b00) || (acc_addr >= ADDR_LIMIT);
`else
    logic addr_unused;
    assign acc_bad     = 1'b0;
    assign addr_unused = ^{acc_addr[DATA_WIDTH-1:IDX_W+2], acc_addr[1:0]};
`endif

    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_next   = wait_cnt;
        unique case (state)
            IDLE: begin
                if (req) begin
                    cnt_next   = CNT_W'(WAIT_STATES);
                    state_next = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_next = wait_cnt - CNT_W'(1);
                if (wait_cnt == CNT_W'(1)) state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Gated by reset so an accept seen during reset can never commit.
    assign enter_resp = reset && (state != RESP) && (state_next == RESP);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            rdata    <= '0;
            ready    <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= cnt_next;
            if (state == IDLE && req) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                we_q    <= we;
            end
            ready <= enter_resp;
            err   <= enter_resp && acc_bad;
            if (enter_resp) rdata <= (acc_we || acc_bad) ? '0 : mem[word_idx];
        end
    end

    // NOTE: the storage array has no reset; clearing it would turn the RAM into
    // a flop bank, and its contents are meant to survive a reset.
    always_ff @(posedge clk) begin
        if (enter_resp && acc_we && !acc_bad) mem[word_idx] <= acc_wdata;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances with 1, 0 and 3 wait states.
// Expectations follow DMEM_ADDR_CHECK_EN when it is defined for the build.
module tb_dmem_responder;

    localparam int NI = 3;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_s [NI];
    logic        req_s   [NI];
    logic        we_s    [NI];
    logic [31:0] addr_s  [NI];
    logic [31:0] wdata_s [NI];
    logic [31:0] rdata_s [NI];
    logic        ready_s [NI];
    logic        err_s   [NI];

    logic [31:0] model_mem [NI][256];
    exp_t        sb [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(256), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .reset(reset_s[0]), .req(req_s[0]), .addr(addr_s[0]), .wdata(wdata_s[0]),
        .we(we_s[0]), .rdata(rdata_s[0]), .ready(ready_s[0]), .err(err_s[0]));

    dmem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(256), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(reset_s[1]), .req(req_s[1]), .addr(addr_s[1]), .wdata(wdata_s[1]),
        .we(we_s[1]), .rdata(rdata_s[1]), .ready(ready_s[1]), .err(err_s[1]));

    dmem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(256), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset(reset_s[2]), .req(req_s[2]), .addr(addr_s[2]), .wdata(wdata_s[2]),
        .we(we_s[2]), .rdata(rdata_s[2]), .ready(ready_s[2]), .err(err_s[2]));

    function automatic int ws_of(input int idx);
        case (idx)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    // Reference behaviour of one access: builds the expected response and
    // updates the model storage.
    function automatic exp_t model_access(input int idx, input logic w,
                                          input logic [31:0] a, input logic [31:0] d);
        exp_t       e;
        logic [7:0] wi;
        logic       bad;
        wi = a[9:2];
`ifdef DMEM_ADDR_CHECK_EN
        bad = (a[1:0] != 2'b00) || (a >= 32'h0000_0400);
`else
        bad = 1'b0;
`endif
        e.err   = bad;
        e.rdata = (w || bad) ? 32'h0 : model_mem[idx][wi];
        if (w && !bad) model_mem[idx][wi] = d;
        return e;
    endfunction

    task automatic do_access(input int idx, input logic w,
                             input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   n;
        sb.push_back(model_access(idx, w, a, d));
        @(negedge clk);
        req_s[idx] = 1'b1; we_s[idx] = w; addr_s[idx] = a; wdata_s[idx] = d;
        @(posedge clk); #1;
        // Drop req and scramble the operands: the access must use latched values.
        req_s[idx] = 1'b0; we_s[idx] = ~w; addr_s[idx] = 32'hFFFF_FFFC; wdata_s[idx] = ~d;
        n = 0;
        while (ready_s[idx] !== 1'b1 && n < 16) begin
            @(posedge clk); #1;
            n++;
        end
        e = sb.pop_front();
        n_checks++;
        if (n >= 16) begin
            n_fail++;
            $display("FAIL access_timeout inst=%0d addr=%h: no ready within 16 cycles", idx, a);
        end else begin
            if (n != ws_of(idx)) begin
                n_fail++;
                $display("FAIL latency inst=%0d addr=%h: got %0d extra edges, want %0d",
                         idx, a, n, ws_of(idx));
            end
            n_checks++;
            if (rdata_s[idx] !== e.rdata) begin
                n_fail++;
                $display("FAIL rdata inst=%0d addr=%h we=%b: got %h, want %h",
                         idx, a, w, rdata_s[idx], e.rdata);
            end
            n_checks++;
            if (err_s[idx] !== e.err) begin
                n_fail++;
                $display("FAIL err inst=%0d addr=%h: got %b, want %b", idx, a, err_s[idx], e.err);
            end
        end
        @(posedge clk); #1;
        n_checks++;
        if (ready_s[idx] !== 1'b0 || err_s[idx] !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse_width inst=%0d: ready=%b err=%b after response, want 0 0",
                     idx, ready_s[idx], err_s[idx]);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < NI; i++) begin
            reset_s[i] = 1'b0; req_s[i] = 1'b0; we_s[i] = 1'b0;
            addr_s[i] = '0; wdata_s[i] = '0;
        end
        req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 32'h40; wdata_s[0] = 32'h1111_1111;
        repeat (3) begin
            @(posedge clk); #1;
            for (int i = 0; i < NI; i++) begin
                n_checks++;
                if (ready_s[i] !== 1'b0 || err_s[i] !== 1'b0 || rdata_s[i] !== 32'h0) begin
                    n_fail++;
                    $display("FAIL reset_state inst=%0d: ready=%b err=%b rdata=%h, want 0 0 0",
                             i, ready_s[i], err_s[i], rdata_s[i]);
                end
            end
        end
        sb.push_back(model_access(0, 1'b1, 32'h40, 32'h1111_1111));
        @(negedge clk);
        for (int i = 0; i < NI; i++) reset_s[i] = 1'b1;
        @(posedge clk); #1;
        req_s[0] = 1'b0;
        n_checks++;
        if (ready_s[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL first_accept_early: ready=%b right after accept edge, want 0", ready_s[0]);
        end
        @(posedge clk); #1;
        e = sb.pop_front();
        n_checks++;
        if (ready_s[0] !== 1'b1 || rdata_s[0] !== e.rdata || err_s[0] !== e.err) begin
            n_fail++;
            $display("FAIL first_accept: ready=%b rdata=%h err=%b, want 1 %h %b",
                     ready_s[0], rdata_s[0], err_s[0], e.rdata, e.err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        do_access(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        do_access(0, 1'b0, 32'h10, 32'h0);
        do_access(0, 1'b0, 32'h40, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        exp_t e;
        vals = '{32'h1, 32'h2, 32'h3, 32'hFFFF_FFFE};
        for (int i = 0; i < 4; i++) do_access(1, 1'b1, 32'(4 * i), vals[i]);
        @(negedge clk);
        req_s[1] = 1'b1; we_s[1] = 1'b0; addr_s[1] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(model_access(1, 1'b0, 32'(4 * i), 32'h0));
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (ready_s[1] !== 1'b1 || rdata_s[1] !== e.rdata || err_s[1] !== e.err) begin
                n_fail++;
                $display("FAIL b2b_load%0d: ready=%b rdata=%h err=%b, want 1 %h %b",
                         i, ready_s[1], rdata_s[1], err_s[1], e.rdata, e.err);
            end
            addr_s[1] = 32'(4 * (i + 1));
            @(posedge clk); #1;
            n_checks++;
            if (ready_s[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_gap%0d: ready=%b in the idle cycle, want 0", i, ready_s[1]);
            end
        end
        req_s[1] = 1'b0;
    endtask

    task automatic test_addr_check();
        do_access(0, 1'b1, 32'h13, 32'h1234_5678);
        do_access(0, 1'b0, 32'h10, 32'h0);
    endtask

    task automatic test_out_of_range();
        do_access(0, 1'b1, 32'h0, 32'hCAFE_0001);
        do_access(0, 1'b0, 32'h400, 32'h0);
        do_access(0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset_mid_wait();
        int seen;
        do_access(2, 1'b1, 32'h20, 32'h0BAD_F00D);
        @(negedge clk);
        req_s[2] = 1'b1; we_s[2] = 1'b1; addr_s[2] = 32'h20; wdata_s[2] = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        req_s[2] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        reset_s[2] = 1'b0;
        #1;
        n_checks++;
        if (ready_s[2] !== 1'b0 || rdata_s[2] !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_wait_reset_state: ready=%b rdata=%h, want 0 0", ready_s[2], rdata_s[2]);
        end
        @(negedge clk);
        reset_s[2] = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ready_s[2] === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL mid_wait_no_ready: got %0d ready pulses, want 0", seen);
        end
        do_access(2, 1'b0, 32'h20, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_back_to_back();
        test_addr_check();
        test_out_of_range();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the pipelined core's data port. Accepts one load or store request at a time over a req/ready handshake, inserts a fixed number of wait states, then completes the access against an internal word-addressed array. It replaces the zero-latency data memory when the pipeline's stall path is exercised, and it sits between the core's MEM stage and storage.

## Interface

Parameters:

- DATA_WIDTH, 32, width of the address and data words.
- DEPTH_WORDS, 256, number of storage words. Must be a power of two.
- WAIT_STATES, 1, extra cycles inserted between accept and response. Legal range is 0..7.

Ports:

- clk  input  1  single clock; every state element is rising-edge triggered.
- reset  input  1  asynchronous active-low reset (0 = in reset).
- req  input  1  access request; the initiator holds it until it observes ready.
- addr  input  DATA_WIDTH  byte address; only word-aligned addresses are legal.
- wdata  input  DATA_WIDTH  store data, sampled at accept.
- we  input  1  1 = store, 0 = load; sampled at accept.
- rdata  output  DATA_WIDTH  load result; registered; valid while ready=1.
- ready  output  1  one-cycle completion pulse.
- err  output  1  completion with error; only meaningful while ready=1.

## Operation

- FSM states are IDLE, WAIT and RESP.
  - IDLE: if req=1 at a rising edge, the block latches addr, wdata and we, and loads wait_cnt=WAIT_STATES. It then goes to WAIT, or directly to RESP if WAIT_STATES=0.
  - WAIT: wait_cnt decrements each cycle. The block moves to RESP on the edge where wait_cnt==1.
  - RESP: ready=1 for exactly one cycle, then the block returns to IDLE unconditionally.
- Requests are accepted in IDLE only. req is ignored in WAIT and RESP.
- If req drops after accept, the access still completes and ready still pulses.
- Word index is addr[log2(DEPTH_WORDS)+1:2].
- Loads: rdata is loaded from the array on the edge entering RESP. rdata holds its value in every other state.
- Stores: the array is written on the edge entering RESP. rdata is set to 0 for a store response.
- Errors (when enabled; see Configuration):
  - An error is either addr[1:0]!=0 or addr >= 4*DEPTH_WORDS.
  - On error: the store is suppressed, rdata=0, and err=1 together with ready.
- Storage is not cleared by reset. Initial contents are 0 at time zero in simulation.

## Timing

- Reset values: ready=0, err=0, rdata=0, state=IDLE, wait_cnt=0.
- Latency: req sampled at edge E0, then ready=1 in the cycle following edge E0+WAIT_STATES. With WAIT_STATES=0, ready appears one cycle after accept.
- Throughput: at most one access per WAIT_STATES+2 cycles, because of the mandatory IDLE cycle after RESP.
- A store followed by a load to the same address returns the new data. No forwarding is needed because the store commits before the load can be accepted.
- Reset asserted mid-operation (WAIT or RESP before the commit edge):
  - the access is abandoned;
  - no ready is produced;
  - no array write happens.
- err and ready rise and fall on the same edges.

## Configuration

- DMEM_ADDR_CHECK_EN defined:
  - misaligned and out-of-range accesses complete with err=1;
  - stores are suppressed and rdata=0.
- DMEM_ADDR_CHECK_EN undefined:
  - err is tied to 0;
  - addr[1:0] is ignored;
  - the word index wraps modulo DEPTH_WORDS;
  - every access completes normally.

## Test plan

- Reset: drive reset=0 while req=1, then release -> ready=0, err=0, rdata=0 throughout. The first accept happens on the first edge after release.
- WAIT_STATES=1: store 0xDEADBEEF at 0x10, then load 0x10 -> each ready arrives 2 cycles after accept, and the load returns rdata=0xDEADBEEF with err=0.
- WAIT_STATES=0: hold req=1 for four consecutive loads of 0x0, 0x4, 0x8, 0xC preloaded with 1, 2, 3, 0xFFFFFFFE -> ready pulses every 2nd cycle with rdata 1, 2, 3, 0xFFFFFFFE in order.
- With DMEM_ADDR_CHECK_EN: store 0x12345678 at 0x13 -> err=1 with ready, and a later load of 0x10 returns its previous value. Without the macro: the same store writes word 4, and a load of 0x10 returns 0x12345678.
- Out of range, DEPTH_WORDS=256: load 0x400 -> with the macro, err=1 and rdata=0; without it, the load returns word 0.
- Reset mid-WAIT: WAIT_STATES=3, store 0xA5A5A5A5 to 0x20, assert reset during the 2nd wait cycle -> no ready pulse, and a later load of 0x20 returns the old value.
